// File: rtl/registers_io.sv
// picoMIPS register file: parametrised GPRs, two read ports, one write port.
// Registers 1/2 map the synchronised, debounced board switches.
module registers_io #(
  parameter int n         = 8,
  parameter int NREGS     = 32,
  parameter int NSW       = 10,
  parameter int DB_CYCLES = 4,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           w,
  input  logic [AW-1:0]  Waddr,
  input  logic [n-1:0]   Wdata,
  input  logic [NSW-1:0] switches,
  input  logic [AW-1:0]  Raddr1,
  input  logic [AW-1:0]  Raddr2,
  output logic [n-1:0]   Rdata1,
  output logic [n-1:0]   Rdata2,
  output logic           in_change,
  output logic           werr
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  localparam logic [AW-1:0] A0 = AW'(0);
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [AW-1:0] A2 = AW'(2);
  localparam logic [AW-1:0] A3 = AW'(3);

  logic [n-1:0]   gpr [NREGS];
  logic [NSW-1:0] sync1, sync2, cand, stable;
  logic [CW-1:0]  cnt;
  logic [n-1:0]   sw_hi;
  logic           wr_ok, wr_ro;

  assign wr_ok = w && (Waddr >= A3);
  assign wr_ro = w && (Waddr < A3);

  // storage registers; low addresses are never written after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (wr_ok) begin
      gpr[Waddr] <= Wdata;
    end
  end

  // one-cycle flag for writes aimed at the read-only addresses
  always_ff @(posedge clk) begin
    if (reset) werr <= 1'b0;
    else       werr <= wr_ro;
  end

  // two-flop synchroniser followed by a stability counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      stable    <= '0;
      cnt       <= '0;
      in_change <= 1'b0;
    end else begin
      sync1     <= switches;
      sync2     <= sync1;
      in_change <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt < CMAX) begin
        cnt <= cnt + 1'b1;
      end else if (cand != stable) begin
        stable    <= cand;
        in_change <= 1'b1;
      end
    end
  end

  // upper switch bits, zero-extended to a full data word
  always_comb begin
    sw_hi = '0;
    sw_hi[NSW-n-1:0] = stable[NSW-1:n];
  end

  function automatic logic [n-1:0] rd(input logic [AW-1:0] a);
    if (a == A0)
      rd = '0;
    else if (a == A1)
      rd = stable[n-1:0];
    else if (a == A2)
      rd = sw_hi;
    else if ((BYPASS != 0) && wr_ok && (a == Waddr))
      rd = Wdata;
    else
      rd = gpr[a];
  endfunction

  // zero-latency read ports with optional write forwarding
  always_comb begin
    Rdata1 = rd(Raddr1);
    Rdata2 = rd(Raddr2);
  end

endmodule
